rv_regfile_sb: RTL and testbench

- Parametrised integer register file for the RV32 core datapath; successor to the fixed 2-read/1-write 32x32 file.
- Generalises data width, register count (RV32I 32 / RV32E 16) and number of read ports.
- Adds:
  - optional write-to-read bypass;
  - a per-register pending scoreboard for in-flight writebacks;
  - a sequential clear engine that zeroes the file without asserting reset.
- Sits between decode (read/alloc) and writeback.

---
 rtl/rv_regfile_sb.sv | 112 +++++++++++
 tb/tb_rv_regfile_sb.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rv_regfile_sb.sv
`default_nettype none
// ============================================================================
//  Module      : rv_regfile_sb
//  Description : Parametrised RV32 integer register file with write-to-read
//                bypass, pending-writeback scoreboard and sequential clear.
//  Revision    : 1.0  initial release
// ============================================================================
module rv_regfile_sb #(
  parameter  int XLEN   = 32,
  parameter  int NREGS  = 32,
  parameter  int NRD    = 2,
  parameter  int BYPASS = 1,
  localparam int AW     = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]      rd_ready,
  input  logic                alloc_en,
  input  logic [AW-1:0]       alloc_addr,
  input  logic                wr_en,
  input  logic [AW-1:0]       wr_addr,
  input  logic [XLEN-1:0]     wr_data,
  input  logic                clear_req,
  output logic                clear_busy,
  output logic [NREGS-1:0]    pending
);

  localparam logic [AW-1:0] LAST_REG = AW'(NREGS - 1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_e;

  state_e                     state_q, state_d;
  logic [AW-1:0]              cnt_q, cnt_d;
  logic [NREGS-1:0][XLEN-1:0] regs_q, regs_d;
  logic [NREGS-1:0]           pend_q, pend_d;
  logic                       idle;

  assign idle       = (state_q == IDLE);
  assign clear_busy = (state_q == CLEAR);
  assign pending    = pend_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      regs_q  <= '0;
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      regs_q  <= regs_d;
      pend_q  <= pend_d;
    end
  end

  // Entry 0 is never written: writes/allocs skip it and the clear starts at 1.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    regs_d  = regs_q;
    pend_d  = pend_q;
    unique case (state_q)
      IDLE: begin
        if (wr_en && (wr_addr != '0)) begin
          regs_d[wr_addr] = wr_data;
          pend_d[wr_addr] = 1'b0;
        end
        // Applied after the writeback clear so a same-register alloc wins.
        if (alloc_en && (alloc_addr != '0)) begin
          pend_d[alloc_addr] = 1'b1;
        end
        if (clear_req) begin
          state_d = CLEAR;
          cnt_d   = AW'(1);
        end
      end
      CLEAR: begin
        regs_d[cnt_q] = '0;
        pend_d[cnt_q] = 1'b0;
        if (cnt_q == LAST_REG) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [AW-1:0] addr;
    logic          byp;

    assign addr = rd_addr[i*AW +: AW];
    assign byp  = (BYPASS != 0) && idle && wr_en && (wr_addr == addr);

    assign rd_data[i*XLEN +: XLEN] = (addr == '0) ? '0 :
                                     byp          ? wr_data : regs_q[addr];
    assign rd_ready[i] = idle && ((addr == '0) || byp || !pend_q[addr]);
  end

endmodule
`default_nettype wire

// File: tb/tb_rv_regfile_sb.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rv_regfile_sb
//  Description : Scoreboard bench for rv_regfile_sb (32x2 bypass, 16x3 no-bypass).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_rv_regfile_sb;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // Instance A: NREGS=32, NRD=2, BYPASS=1
  logic [9:0]  a_rd_addr;
  logic [63:0] a_rd_data;
  logic [1:0]  a_rd_ready;
  logic        a_alloc_en, a_wr_en, a_clear_req, a_busy;
  logic [4:0]  a_alloc_addr, a_wr_addr;
  logic [31:0] a_wr_data, a_pending;

  // Instance B: NREGS=16, NRD=3, BYPASS=0
  logic [11:0] b_rd_addr;
  logic [95:0] b_rd_data;
  logic [2:0]  b_rd_ready;
  logic        b_alloc_en, b_wr_en, b_clear_req, b_busy;
  logic [3:0]  b_alloc_addr, b_wr_addr;
  logic [31:0] b_wr_data;
  logic [15:0] b_pending;

  rv_regfile_sb #(.XLEN(32), .NREGS(32), .NRD(2), .BYPASS(1)) u_dut_a (
    .clk(clk), .rst_n(rst_n),
    .rd_addr(a_rd_addr), .rd_data(a_rd_data), .rd_ready(a_rd_ready),
    .alloc_en(a_alloc_en), .alloc_addr(a_alloc_addr),
    .wr_en(a_wr_en), .wr_addr(a_wr_addr), .wr_data(a_wr_data),
    .clear_req(a_clear_req), .clear_busy(a_busy), .pending(a_pending)
  );

  rv_regfile_sb #(.XLEN(32), .NREGS(16), .NRD(3), .BYPASS(0)) u_dut_b (
    .clk(clk), .rst_n(rst_n),
    .rd_addr(b_rd_addr), .rd_data(b_rd_data), .rd_ready(b_rd_ready),
    .alloc_en(b_alloc_en), .alloc_addr(b_alloc_addr),
    .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data),
    .clear_req(b_clear_req), .clear_busy(b_busy), .pending(b_pending)
  );

  // kind: 0 A data, 1 A ready, 2 A pending, 3 A busy, 4..7 same for B
  typedef struct {
    int          kind;
    int          port;
    logic [63:0] val;
    string       nm;
  } exp_t;

  exp_t q[$];
  int   chk_cnt  = 0;
  int   pass_cnt = 0;

  function automatic void ex(int k, int p, logic [63:0] v, string n);
    exp_t e;
    e.kind = k; e.port = p; e.val = v; e.nm = n;
    q.push_back(e);
  endfunction

  function automatic logic [63:0] actual(int k, int p);
    case (k)
      0: return 64'(a_rd_data[p*32 +: 32]);
      1: return 64'(a_rd_ready[p]);
      2: return 64'(a_pending);
      3: return 64'(a_busy);
      4: return 64'(b_rd_data[p*32 +: 32]);
      5: return 64'(b_rd_ready[p]);
      6: return 64'(b_pending);
      default: return 64'(b_busy);
    endcase
  endfunction

  always @(negedge clk) begin
    while (q.size() > 0) begin
      exp_t        e;
      logic [63:0] act;
      e   = q.pop_front();
      act = actual(e.kind, e.port);
      chk_cnt++;
      if (act === e.val) pass_cnt++;
      else $display("FAIL %s port%0d: got 0x%0h expected 0x%0h at %0t",
                    e.nm, e.port, act, e.val, $time);
    end
  end

  task automatic tick();
    @(negedge clk); #1;
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    a_rd_addr = {5'd31, 5'd5}; a_alloc_en = 0; a_alloc_addr = 0;
    a_wr_en = 0; a_wr_addr = 0; a_wr_data = 0; a_clear_req = 0;
    b_rd_addr = {4'd15, 4'd0, 4'd5}; b_alloc_en = 0; b_alloc_addr = 0;
    b_wr_en = 0; b_wr_addr = 0; b_wr_data = 0; b_clear_req = 0;
    @(posedge clk); #1;

    // Reset state
    ex(0, 0, 0, "rst_data"); ex(0, 1, 0, "rst_data");
    ex(1, 0, 1, "rst_ready"); ex(1, 1, 1, "rst_ready");
    ex(2, 0, 0, "rst_pending"); ex(3, 0, 0, "rst_busy");
    for (int p = 0; p < 3; p++) begin
      ex(4, p, 0, "b_rst_data"); ex(5, p, 1, "b_rst_ready");
    end
    ex(6, 0, 0, "b_rst_pending"); ex(7, 0, 0, "b_rst_busy");
    tick();
    rst_n = 1'b1;
    tick();

    // Same-cycle bypass of x5
    a_wr_en = 1; a_wr_addr = 5; a_wr_data = 32'hDEADBEEF;
    ex(0, 0, 64'hDEADBEEF, "bypass_data"); ex(1, 0, 1, "bypass_ready");
    ex(0, 1, 0, "x31_data"); ex(1, 1, 1, "x31_ready");
    tick();
    a_wr_en = 0;
    ex(0, 0, 64'hDEADBEEF, "stored_x5");
    tick();

    // Alloc x7, then writeback bypassed while pending
    a_rd_addr = {5'd9, 5'd7}; a_alloc_en = 1; a_alloc_addr = 7;
    ex(1, 0, 1, "pre_alloc_ready"); ex(2, 0, 0, "pre_alloc_pending");
    tick();
    a_alloc_en = 0;
    ex(1, 0, 0, "alloc_ready"); ex(2, 0, 64'h80, "alloc_pending");
    tick();
    a_wr_en = 1; a_wr_addr = 7; a_wr_data = 32'h1234;
    ex(0, 0, 64'h1234, "wb_bypass_data"); ex(1, 0, 1, "wb_bypass_ready");
    ex(2, 0, 64'h80, "wb_pending_before");
    tick();
    a_wr_en = 0;
    ex(2, 0, 0, "wb_pending_after"); ex(1, 0, 1, "wb_ready_after");
    ex(0, 0, 64'h1234, "wb_stored");
    tick();

    // Same-cycle alloc and write x9: alloc wins
    a_wr_en = 1; a_wr_addr = 9; a_wr_data = 32'h55;
    a_alloc_en = 1; a_alloc_addr = 9;
    ex(0, 1, 64'h55, "aw_bypass_data");
    tick();
    // Write and alloc x0 are ignored
    a_rd_addr = {5'd9, 5'd0};
    a_wr_addr = 0; a_wr_data = 32'hFFFF_FFFF; a_alloc_addr = 0;
    ex(2, 0, 64'h200, "aw_pending"); ex(0, 1, 64'h55, "aw_stored");
    ex(1, 1, 0, "aw_ready"); ex(0, 0, 0, "x0_wr_data"); ex(1, 0, 1, "x0_wr_ready");
    tick();
    a_wr_en = 0; a_alloc_en = 0;
    ex(2, 0, 64'h200, "x0_pending"); ex(0, 0, 0, "x0_data");
    tick();

    // Load x1..x31
    for (int r = 1; r < 32; r++) begin
      a_wr_en = 1; a_wr_addr = 5'(r); a_wr_data = 32'h1000_0000 + 32'(r);
      tick();
    end
    a_wr_en = 0; a_rd_addr = {5'd31, 5'd3};
    ex(0, 0, 64'h1000_0003, "load_x3"); ex(0, 1, 64'h1000_001F, "load_x31");
    ex(3, 0, 0, "pre_clear_busy");
    a_clear_req = 1;
    tick();
    a_clear_req = 0;

    for (int c = 1; c <= 31; c++) begin
      a_wr_en = 0; a_alloc_en = 0;
      ex(3, 0, 1, "clear_busy"); ex(1, 0, 0, "clear_ready"); ex(1, 1, 0, "clear_ready");
      if (c == 5) begin
        a_wr_en = 1; a_wr_addr = 3; a_wr_data = 32'hABCD;
        a_alloc_en = 1; a_alloc_addr = 3;
        ex(0, 0, 0, "clear_no_bypass"); ex(0, 1, 64'h1000_001F, "clear_x31_held");
      end
      tick();
    end
    a_wr_en = 0; a_alloc_en = 0;
    ex(3, 0, 0, "clear_done_busy"); ex(2, 0, 0, "clear_done_pending");
    for (int r = 1; r < 32; r++) begin
      a_rd_addr = {5'd0, 5'(r)};
      ex(0, 0, 0, "cleared_data"); ex(1, 0, 1, "cleared_ready");
      tick();
    end

    // Async reset during CLEAR
    a_wr_en = 1; a_wr_addr = 20; a_wr_data = 32'h2020; tick();
    a_wr_en = 0; a_alloc_en = 1; a_alloc_addr = 6; tick();
    a_alloc_en = 0; a_clear_req = 1; tick();
    a_clear_req = 0; a_rd_addr = {5'd6, 5'd20};
    for (int c = 1; c <= 9; c++) begin
      ex(3, 0, 1, "mid_busy");
      tick();
    end
    rst_n = 1'b0;
    ex(3, 0, 0, "arst_busy"); ex(0, 0, 0, "arst_x20"); ex(2, 0, 0, "arst_pending");
    ex(1, 0, 1, "arst_ready"); ex(1, 1, 1, "arst_ready");
    tick();
    rst_n = 1'b1;
    ex(3, 0, 0, "post_arst_busy"); ex(0, 0, 0, "post_arst_x20");
    tick();

    // Instance B: no bypass
    b_wr_en = 1; b_wr_addr = 5; b_wr_data = 32'hDEADBEEF;
    ex(4, 0, 0, "b_nobyp_data"); ex(5, 0, 1, "b_nobyp_ready");
    ex(4, 1, 0, "b_x0_data"); ex(5, 1, 1, "b_x0_ready");
    ex(4, 2, 0, "b_x15_data"); ex(5, 2, 1, "b_x15_ready");
    tick();
    b_wr_en = 0; b_alloc_en = 1; b_alloc_addr = 15;
    ex(4, 0, 64'hDEADBEEF, "b_stored_x5");
    tick();
    b_alloc_en = 0; b_wr_en = 1; b_wr_addr = 15; b_wr_data = 32'h7;
    ex(5, 2, 0, "b_pend_ready"); ex(4, 2, 0, "b_pend_data"); ex(6, 0, 64'h8000, "b_pending");
    tick();
    b_wr_en = 0;
    ex(5, 2, 1, "b_wb_ready"); ex(4, 2, 7, "b_wb_data"); ex(6, 0, 0, "b_wb_pending");
    tick();

    // Held clear_req: 15 busy, one idle cycle, restart
    b_clear_req = 1;
    ex(7, 0, 0, "b_pre_busy");
    tick();
    for (int c = 1; c <= 15; c++) begin
      ex(7, 0, 1, "b_busy");
      for (int p = 0; p < 3; p++) ex(5, p, 0, "b_clear_ready");
      tick();
    end
    ex(7, 0, 0, "b_gap_busy");
    tick();
    b_clear_req = 0;
    for (int c = 1; c <= 15; c++) begin
      ex(7, 0, 1, "b_busy2");
      tick();
    end
    ex(7, 0, 0, "b_done_busy"); ex(4, 0, 0, "b_done_x5"); ex(4, 2, 0, "b_done_x15");
    ex(5, 0, 1, "b_done_ready");
    tick();

    if (q.size() != 0) begin
      chk_cnt++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", q.size());
    end
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
`default_nettype wire
